msrv32_regfile_sb: RTL and testbench

MSRV32_REGFILE_SB -- requirements
Module: msrv32_regfile_sb

---
 rtl/msrv32_regfile_sb.sv | 96 +++++++++
 tb/tb_msrv32_regfile_sb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/msrv32_regfile_sb.sv
// msrv32_regfile_sb: register file with two write ports, NUM_RD bypassed read ports
// and a busy-bit scoreboard for outstanding producers.
//   msrv32_mp_clk_in / msrv32_mp_rst_in : clock, asynchronous active-low reset
//   wr_*_a_in, wr_*_b_in                : ALU / load writeback ports (B wins on collision)
//   rs_addr_in / rs_data_out            : packed read addresses / combinational read data
//   issue_en_in / issue_rd_addr_in      : mark a destination register busy
//   flush_in                            : clear every busy bit
//   stall_out, busy_out, pending_cnt_out: hazard flag, busy vector, busy count
module msrv32_regfile_sb #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                         msrv32_mp_clk_in,
    input  logic                         msrv32_mp_rst_in,
    input  logic                         wr_en_a_in,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_a_in,
    input  logic [WIDTH-1:0]             wr_data_a_in,
    input  logic                         wr_en_b_in,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_b_in,
    input  logic [WIDTH-1:0]             wr_data_b_in,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_in,
    output logic [NUM_RD*WIDTH-1:0]      rs_data_out,
    input  logic                         issue_en_in,
    input  logic [ADDR_WIDTH-1:0]        issue_rd_addr_in,
    input  logic                         flush_in,
    output logic                         stall_out,
    output logic [DEPTH-1:0]             busy_out,
    output logic [CNT_WIDTH-1:0]         pending_cnt_out
);
    logic [WIDTH-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]     busy_q, busy_d, set_v, clr_v;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 a_ok, b_ok, issue_ok, inc, dec_a, dec_b;
    logic [NUM_RD-1:0]    stall_v;

    assign a_ok     = wr_en_a_in && wr_addr_a_in != '0;
    assign b_ok     = wr_en_b_in && wr_addr_b_in != '0;
    assign issue_ok = issue_en_in && issue_rd_addr_in != '0 && !flush_in;

    // Port B is written last so it overrides port A on a same-address collision.
    always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
        if (!msrv32_mp_rst_in) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (a_ok) regs[wr_addr_a_in] <= wr_data_a_in;
            if (b_ok) regs[wr_addr_b_in] <= wr_data_b_in;
        end
    end

    // A new producer's set overrides a retiring producer's clear.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 1; i < DEPTH; i++) begin
            set_v[i] = issue_ok && issue_rd_addr_in == ADDR_WIDTH'(i);
            clr_v[i] = (a_ok && wr_addr_a_in == ADDR_WIDTH'(i)) || (b_ok && wr_addr_b_in == ADDR_WIDTH'(i));
        end
        busy_d = flush_in ? '0 : (busy_q & ~clr_v) | set_v;
    end

    // Incremental count mirrors busy_d: +1 for a newly busy register, -1 per
    // distinct busy register retired without being re-issued.
    assign inc   = issue_ok && !busy_q[issue_rd_addr_in];
    assign dec_a = a_ok && busy_q[wr_addr_a_in] && !(issue_ok && issue_rd_addr_in == wr_addr_a_in);
    assign dec_b = b_ok && busy_q[wr_addr_b_in] && !(issue_ok && issue_rd_addr_in == wr_addr_b_in)
                   && !(a_ok && wr_addr_a_in == wr_addr_b_in);
    assign cnt_d = flush_in ? '0 : cnt_q + CNT_WIDTH'(inc) - CNT_WIDTH'(dec_a) - CNT_WIDTH'(dec_b);

    always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
        if (!msrv32_mp_rst_in) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  ha, hb;
        assign a  = rs_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign ha = wr_en_a_in && wr_addr_a_in == a;
        assign hb = wr_en_b_in && wr_addr_b_in == a;
        assign rs_data_out[k*WIDTH +: WIDTH] = (!msrv32_mp_rst_in || a == '0) ? '0 :
                                              hb ? wr_data_b_in : ha ? wr_data_a_in : regs[a];
        assign stall_v[k] = busy_q[a] && a != '0 && !ha && !hb;
    end

    assign stall_out       = |stall_v;
    assign busy_out        = busy_q;
    assign pending_cnt_out = cnt_q;
endmodule

// File: tb/tb_msrv32_regfile_sb.sv
// tb_msrv32_regfile_sb: table-driven check of reads, bypass, scoreboard and reset behaviour.
module tb_msrv32_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wa_en, wb_en, iss, fl;
    logic [4:0]  wa_addr, wb_addr, iaddr, rs0, rs1;
    logic [31:0] wa_data, wb_data;
    logic [63:0] rd;
    logic        stall;
    logic [31:0] busy;
    logic [5:0]  cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    msrv32_regfile_sb dut (
        .msrv32_mp_clk_in(clk), .msrv32_mp_rst_in(rst_n),
        .wr_en_a_in(wa_en), .wr_addr_a_in(wa_addr), .wr_data_a_in(wa_data),
        .wr_en_b_in(wb_en), .wr_addr_b_in(wb_addr), .wr_data_b_in(wb_data),
        .rs_addr_in({rs1, rs0}), .rs_data_out(rd),
        .issue_en_in(iss), .issue_rd_addr_in(iaddr), .flush_in(fl),
        .stall_out(stall), .busy_out(busy), .pending_cnt_out(cnt)
    );

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [4:0]  rs0, rs1;
        logic        iss;
        logic [4:0]  iaddr;
        logic        fl;
        logic [31:0] e_rd0, e_rd1;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        iss = 0; iaddr = 0; fl = 0; rs0 = 0; rs1 = 0;
    endtask

    initial begin
        //        waE wa  wa_data        wbE wb  wb_data       rs0 rs1 iss ia  fl  e_rd0          e_rd1         st e_busy        cnt
        vt[0]  = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  5,  0, 0,  0, 32'h0,         32'h0,         0, 32'h0,        0};
        vt[1]  = '{1, 5,  32'h0000_1234, 0, 0,  32'h0,         5,  0,  0, 0,  0, 32'h0000_1234, 32'h0,         0, 32'h0,        0};
        vt[2]  = '{0, 0,  32'h0,         0, 0,  32'h0,         5,  0,  0, 0,  0, 32'h0000_1234, 32'h0,         0, 32'h0,        0};
        vt[3]  = '{1, 7,  32'h11,        1, 7,  32'h22,        7,  5,  0, 0,  0, 32'h22,        32'h0000_1234, 0, 32'h0,        0};
        vt[4]  = '{0, 0,  32'h0,         0, 0,  32'h0,         7,  7,  0, 0,  0, 32'h22,        32'h22,        0, 32'h0,        0};
        vt[5]  = '{0, 0,  32'h0,         0, 0,  32'h0,         3,  0,  1, 3,  0, 32'h0,         32'h0,         0, 32'h0,        0};
        vt[6]  = '{0, 0,  32'h0,         0, 0,  32'h0,         3,  0,  0, 0,  0, 32'h0,         32'h0,         1, 32'h8,        1};
        vt[7]  = '{1, 3,  32'hAB,        0, 0,  32'h0,         3,  0,  0, 0,  0, 32'hAB,        32'h0,         0, 32'h8,        1};
        vt[8]  = '{0, 0,  32'h0,         0, 0,  32'h0,         3,  0,  0, 0,  0, 32'hAB,        32'h0,         0, 32'h0,        0};
        vt[9]  = '{0, 0,  32'h0,         1, 4,  32'h44,        4,  0,  1, 4,  0, 32'h44,        32'h0,         0, 32'h0,        0};
        vt[10] = '{0, 0,  32'h0,         0, 0,  32'h0,         4,  0,  0, 0,  0, 32'h44,        32'h0,         1, 32'h10,       1};
        vt[11] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 1,  0, 32'h0,         32'h0,         0, 32'h10,       1};
        vt[12] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 2,  0, 32'h0,         32'h0,         0, 32'h12,       2};
        vt[13] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 9,  0, 32'h0,         32'h0,         0, 32'h16,       3};
        vt[14] = '{1, 11, 32'h5A5A,      0, 0,  32'h0,         9,  11, 1, 10, 1, 32'h0,         32'h5A5A,      1, 32'h216,      4};
        vt[15] = '{0, 0,  32'h0,         0, 0,  32'h0,         10, 11, 0, 0,  0, 32'h0,         32'h5A5A,      0, 32'h0,        0};
        vt[16] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 8,  0, 32'h0,         32'h0,         0, 32'h0,        0};
        vt[17] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 8,  0, 32'h0,         32'h0,         0, 32'h100,      1};
        vt[18] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  0,  1, 12, 0, 32'h0,         32'h0,         0, 32'h100,      1};
        vt[19] = '{1, 8,  32'h88,        1, 12, 32'hCC,        8,  12, 0, 0,  0, 32'h88,        32'hCC,        0, 32'h1100,     2};
        vt[20] = '{1, 0,  32'hDEAD,      1, 0,  32'hBEEF,      8,  0,  0, 0,  0, 32'h88,        32'h0,         0, 32'h0,        0};
        vt[21] = '{0, 0,  32'h0,         0, 0,  32'h0,         0,  12, 0, 0,  0, 32'h0,         32'hCC,        0, 32'h0,        0};

        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            wa_en = vt[i].wa_en; wa_addr = vt[i].wa_addr; wa_data = vt[i].wa_data;
            wb_en = vt[i].wb_en; wb_addr = vt[i].wb_addr; wb_data = vt[i].wb_data;
            rs0 = vt[i].rs0; rs1 = vt[i].rs1; iss = vt[i].iss; iaddr = vt[i].iaddr; fl = vt[i].fl;
            #2;
            check($sformatf("vec%0d {rd1,rd0,stall,busy,cnt}", i),
                  {rd[63:32], rd[31:0], stall, busy, cnt},
                  {vt[i].e_rd1, vt[i].e_rd0, vt[i].e_stall, vt[i].e_busy, vt[i].e_cnt});
        end

        // Asynchronous reset between edges wipes a just-written register.
        @(negedge clk);
        idle(); wa_en = 1; wa_addr = 6; wa_data = 32'hFFFF_FFFF; rs0 = 6; iss = 1; iaddr = 13;
        #2 check("x6 bypass", rd[31:0], 32'hFFFF_FFFF);
        @(negedge clk);
        idle(); rs0 = 6;
        #2 check("x6 stored", rd[31:0], 32'hFFFF_FFFF);
        check("x13 busy before reset", {busy, cnt}, {32'h2000, 6'd1});
        #1 rst_n = 0;
        #1 check("x6 during reset", rd[31:0], 32'h0);
        check("state during reset", {stall, busy, cnt}, {1'b0, 32'h0, 6'd0});
        wa_en = 1; wa_addr = 6; wa_data = 32'h99; iss = 1; iaddr = 6; rs1 = 6;
        #1 check("bypass blocked in reset", rd, 64'h0);
        @(negedge clk);
        check("ignored in reset", {rd, busy, cnt}, {64'h0, 32'h0, 6'd0});
        #1 idle(); rs0 = 6;
        #1 rst_n = 1;
        @(negedge clk);
        #2 check("x6 after release", {rd[31:0], busy, cnt, stall}, {32'h0, 32'h0, 6'd0, 1'b0});
        @(negedge clk);
        wa_en = 1; wa_addr = 6; wa_data = 32'h77; iss = 1; iaddr = 14;
        @(negedge clk);
        idle(); rs0 = 14; rs1 = 6;
        #2 check("first write after release", {rd[63:32], busy, cnt, stall}, {32'h77, 32'h4000, 6'd1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
